// File: rtl/pps_time_of_day.sv
// rtl/pps_time_of_day.sv - PPS edge to second strobe, BCD hh:mm:ss and source-valid flag
// Optional PPS_PERIOD_MEAS_EN: o_period reports cycles between the last two ticks.
module pps_time_of_day #(
  parameter int CLOCK_RATE_HZ = 12_000_000,
  parameter int LOSS_CYCLES   = CLOCK_RATE_HZ + CLOCK_RATE_HZ / 4,
  parameter int PW            = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_pps,
  input  logic          i_clear,
  output logic          o_tick,
  output logic [7:0]    o_sec,
  output logic [7:0]    o_min,
  output logic [7:0]    o_hour,
  output logic          o_valid,
  output logic [PW-1:0] o_period
);

  localparam logic [PW-1:0] LP_LOSS = PW'(LOSS_CYCLES);
  localparam logic [PW-1:0] LP_MAX  = '1;

  logic          r_s1, r_s2, r_last, r_tick;
  logic          r_armed, r_valid;
  logic [PW-1:0] r_count;
  logic [7:0]    r_sec, r_min, r_hour;
  logic [7:0]    w_sec_nxt, w_min_nxt, w_hour_nxt;
  logic [8:0]    w_sec_inc, w_min_inc, w_hour_inc;
  logic          w_rise;

  // Returns {wrap, next}; wrap is set when v was at its last legal value.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)
      return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_rise     = r_s2 & ~r_last;
  assign w_sec_inc  = bcd_inc(r_sec,  8'h59);
  assign w_min_inc  = bcd_inc(r_min,  8'h59);
  assign w_hour_inc = bcd_inc(r_hour, 8'h23);

  always_comb begin
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour;
    if (i_clear) begin
      w_sec_nxt  = 8'h00;
      w_min_nxt  = 8'h00;
      w_hour_nxt = 8'h00;
    end else if (w_rise) begin
      w_sec_nxt = w_sec_inc[7:0];
      if (w_sec_inc[8])
        w_min_nxt = w_min_inc[7:0];
      if (w_sec_inc[8] && w_min_inc[8])
        w_hour_nxt = w_hour_inc[7:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_last  <= 1'b0;
      r_tick  <= 1'b0;
      r_sec   <= 8'h00;
      r_min   <= 8'h00;
      r_hour  <= 8'h00;
      r_count <= '0;
      r_armed <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_s1   <= i_pps;
      r_s2   <= r_s1;
      r_last <= r_s2;
      r_tick <= w_rise;
      r_sec  <= w_sec_nxt;
      r_min  <= w_min_nxt;
      r_hour <= w_hour_nxt;
      if (w_rise) begin
        // First tick after reset or loss only arms; the second proves the interval.
        r_count <= PW'(1);
        r_armed <= 1'b1;
        if (r_armed)
          r_valid <= (r_count < LP_LOSS);
      end else begin
        if (r_count != LP_MAX)
          r_count <= r_count + PW'(1);
        if (r_count >= LP_LOSS) begin
          r_valid <= 1'b0;
          r_armed <= 1'b0;
        end
      end
    end
  end

`ifdef PPS_PERIOD_MEAS_EN
  logic [PW-1:0] r_period;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_period <= '0;
    else if (w_rise && r_armed)
      r_period <= r_count;
  end

  assign o_period = r_period;
`else
  assign o_period = '0;
`endif

  assign o_tick  = r_tick;
  assign o_sec   = r_sec;
  assign o_min   = r_min;
  assign o_hour  = r_hour;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_pps_time_of_day.sv
// tb/tb_pps_time_of_day.sv - directed self-checking bench for pps_time_of_day
`timescale 1ns/1ps
module tb_pps_time_of_day;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        pps   = 1'b0;
  logic        clr   = 1'b0;
  logic        o_tick, o_valid;
  logic [7:0]  o_sec, o_min, o_hour;
  logic [31:0] o_period;

  int n_checks = 0;
  int n_errors = 0;
  int tod      = 0;

  pps_time_of_day #(.CLOCK_RATE_HZ(100), .LOSS_CYCLES(150), .PW(32)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_pps(pps), .i_clear(clr),
    .o_tick(o_tick), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_valid(o_valid), .o_period(o_period)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] exp_per(input logic [31:0] p);
`ifdef PPS_PERIOD_MEAS_EN
    return p;
`else
    if (p == 32'hFFFF_FFFF) return 32'd1;
    return 32'd0;
`endif
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_tick"},   o_tick,   0);
    check({tag, "_sec"},    o_sec,    0);
    check({tag, "_min"},    o_min,    0);
    check({tag, "_hour"},   o_hour,   0);
    check({tag, "_valid"},  o_valid,  0);
    check({tag, "_period"}, o_period, 0);
  endtask

  // One PPS period of `total` cycles; the tick edge is the 3rd edge after the rise.
  task automatic pps_period(input bit c, input int total, input logic ev, input logic [31:0] ep);
    pps = 1'b1;
    step();
    step();
    check("tick_early", o_tick, 0);
    clr = c;
    step();
    clr = 1'b0;
    tod = c ? 0 : (tod + 1) % 86400;
    check("tick_on",    o_tick,   1);
    check("tod_sec",    o_sec,    bcd(tod % 60));
    check("tod_min",    o_min,    bcd((tod / 60) % 60));
    check("tod_hour",   o_hour,   bcd(tod / 3600));
    check("valid",      o_valid,  ev);
    check("period",     o_period, exp_per(ep));
    step();
    check("tick_width", o_tick, 0);
    for (int k = 4; k < total; k++) begin
      if (k == 50) pps = 1'b0;
      step();
    end
    pps = 1'b0;
  endtask

  initial begin
    #2;
    check_zero("rst_async");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      check("idle_no_tick", o_tick, 0);
    end
    check_zero("idle");

    // Acquisition: first tick arms, second validates and measures.
    pps_period(1'b0, 100, 1'b0, 32'd0);
    pps_period(1'b0, 100, 1'b1, 32'd100);
    pps_period(1'b0, 100, 1'b1, 32'd100);
    pps_period(1'b0, 100, 1'b1, 32'd100);

    // Clear collides with the tick that would show 00:00:05.
    pps_period(1'b1, 100, 1'b1, 32'd100);
    check("clr_sec", o_sec, 8'h00);
    pps_period(1'b0, 100, 1'b1, 32'd100);
    check("after_clr_sec", o_sec, 8'h01);

    for (int i = 0; i < 64; i++) begin
      pps_period(1'b0, 100, 1'b1, 32'd100);
      if (tod == 10) check("carry_09_10", o_sec, 8'h10);
      if (tod == 60) check("carry_59_00", {o_min, o_sec}, 16'h0100);
    end
    check("at_0105", {o_hour, o_min, o_sec}, 24'h000105);

    // Source loss: o_valid drops 150 edges after the last tick edge.
    repeat (52) step();
    check("valid_149", o_valid, 1);
    step();
    check("valid_150", o_valid, 0);
    pps_period(1'b0, 100, 1'b0, 32'd100);
    pps_period(1'b0, 60,  1'b1, 32'd100);
    check("at_0107", {o_hour, o_min, o_sec}, 24'h000107);

    // Asynchronous reset mid-second.
    rst_n = 1'b0;
    #2;
    check_zero("rst_mid");
    step();
    rst_n = 1'b1;
    tod = 0;
    pps_period(1'b0, 100, 1'b0, 32'd0);
    pps_period(1'b0, 99,  1'b1, 32'd100);

    // Preload 23:59:58 and roll over midnight.
    force dut.r_hour = 8'h23;
    force dut.r_min  = 8'h59;
    force dut.r_sec  = 8'h58;
    step();
    release dut.r_hour;
    release dut.r_min;
    release dut.r_sec;
    tod = 86398;
    pps_period(1'b0, 100, 1'b1, 32'd100);
    check("at_235959", {o_hour, o_min, o_sec}, 24'h235959);
    pps_period(1'b0, 100, 1'b1, 32'd100);
    check("midnight", {o_hour, o_min, o_sec}, 24'h000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
